// File: rtl/multiplier_control_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared types and constants for the shift-add multiplier controller.
//   Contents:
//     mult_state_t        - sequencing states IDLE/CLR/ADD/SHIFT/HOLD
//     MULT_WIDTH_DEFAULT  - default operand width (add/shift iterations)
//     is_busy_state()     - true for the states in which a multiply is running
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_t;

  localparam int MULT_WIDTH_DEFAULT = 32'sd8;

  // Busy covers the whole datapath sequence, from the clear through the last shift.
  function automatic logic is_busy_state(input mult_state_t st);
    logic busy_s;
    case (st)
      CLR, ADD, SHIFT: busy_s = 1'b1;
      default:         busy_s = 1'b0;
    endcase
    return busy_s;
  endfunction

endpackage

// File: rtl/multiplier_control_if.sv
// -----------------------------------------------------------------------------
// multiplier_control_if
//   Bundle between the buttons/datapath side and the multiplier controller.
//   Signals:
//     Run, ClearA_LoadB  raw active-low push-buttons
//     M                  LSB of register B from the datapath
//     ClearXA, LoadB, Add, Sub, Shift   per-cycle datapath strobes
//     Busy, Done         status
//   Modports:
//     master - buttons/datapath side (drives buttons and M, reads strobes)
//     slave  - controller side
// -----------------------------------------------------------------------------
interface multiplier_control_if;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic ClearXA;
  logic LoadB;
  logic Add;
  logic Sub;
  logic Shift;
  logic Busy;
  logic Done;

  modport master (
    output Run, ClearA_LoadB, M,
    input  ClearXA, LoadB, Add, Sub, Shift, Busy, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output ClearXA, LoadB, Add, Sub, Shift, Busy, Done
  );
endinterface

// File: rtl/multiplier_control_sync_button.sv
// -----------------------------------------------------------------------------
// sync_button
//   Two-flop synchronizer for an active-low push-button. Both flops reset to
//   1 so a reset always looks like "button released" to the controller.
//   Ports:
//     Clk       system clock
//     Reset     asynchronous active-low reset
//     button_n  raw asynchronous button level (active-low)
//     sync_n    synchronized button level (active-low)
// -----------------------------------------------------------------------------
module sync_button (
  input  logic Clk,
  input  logic Reset,
  input  logic button_n,
  output logic sync_n
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous button level.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= button_n;
      sync_r <= meta_r;
    end
  end

  assign sync_n = sync_r;

endmodule

// File: rtl/multiplier_control.sv
// -----------------------------------------------------------------------------
// multiplier_control
//   Sequencing controller for a shift-add multiplier. One Run press gives one
//   complete multiply of WIDTH add/shift iterations, then the controller holds
//   Done until Run is released. ClearA_LoadB in IDLE loads B and clears X/A.
//   Optional build macro: MULT_CTRL_SIGNED_EN - the last iteration subtracts
//   instead of adding (two's-complement signed multiply).
//   Parameters:
//     WIDTH   operand width / iteration count (>= 2)
//   Ports:
//     Clk     system clock, rising edge
//     Reset   asynchronous active-low reset
//     bus     multiplier_control_if.slave (buttons, M, strobes, status)
// -----------------------------------------------------------------------------
module multiplier_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input logic                  Clk,
  input logic                  Reset,
  multiplier_control_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mult_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             clear_r;
  logic             load_r;
  logic             shift_r;
  logic             busy_r;
  logic             done_r;
  logic             runs_s;
  logic             clrs_s;
  logic             add_s;
  logic             sub_s;

  sync_button u_sync_run (
    .Clk      (Clk),
    .Reset    (Reset),
    .button_n (bus.Run),
    .sync_n   (runs_s)
  );

  sync_button u_sync_clr (
    .Clk      (Clk),
    .Reset    (Reset),
    .button_n (bus.ClearA_LoadB),
    .sync_n   (clrs_s)
  );

  // State, iteration count and the registered strobes. Each strobe is loaded
  // together with the state it belongs to, so it is valid for that state's cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      clear_r <= 1'b0;
      load_r  <= 1'b0;
      shift_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      clear_r <= 1'b0;
      load_r  <= 1'b0;
      shift_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          // Run wins over ClearA_LoadB when both are pressed.
          if (!runs_s) begin
            state_r <= CLR;
            clear_r <= 1'b1;
          end else if (!clrs_s) begin
            state_r <= IDLE;
            load_r  <= 1'b1;
            clear_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        CLR: begin
          cnt_r   <= '0;
          state_r <= ADD;
        end
        ADD: begin
          state_r <= SHIFT;
          shift_r <= 1'b1;
        end
        SHIFT: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_r <= HOLD;
            done_r  <= 1'b1;
          end else begin
            state_r <= ADD;
          end
        end
        HOLD: begin
          // No re-trigger until Run has been seen released.
          if (runs_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
      busy_r <= is_busy_state(next_busy_state(state_r, runs_s, cnt_r));
    end
  end

  // Busy follows the state being entered, matching the other registered strobes.
  function automatic mult_state_t next_busy_state(input mult_state_t st,
                                                  input logic runs,
                                                  input logic [CNT_W-1:0] cnt);
    mult_state_t nxt_s;
    case (st)
      IDLE:    nxt_s = runs ? IDLE : CLR;
      CLR:     nxt_s = ADD;
      ADD:     nxt_s = SHIFT;
      SHIFT:   nxt_s = (cnt == LAST_CNT) ? HOLD : ADD;
      default: nxt_s = IDLE;
    endcase
    return nxt_s;
  endfunction

  // Add/Sub are gated by M in the ADD cycle itself: B only shifts in SHIFT,
  // so the live M is the multiplier bit for this iteration.
`ifdef MULT_CTRL_SIGNED_EN
  assign add_s = (state_r == ADD) && bus.M && (cnt_r != LAST_CNT);
  assign sub_s = (state_r == ADD) && bus.M && (cnt_r == LAST_CNT);
`else
  assign add_s = (state_r == ADD) && bus.M;
  assign sub_s = 1'b0;
`endif

  assign bus.ClearXA = clear_r;
  assign bus.LoadB   = load_r;
  assign bus.Add     = add_s;
  assign bus.Sub     = sub_s;
  assign bus.Shift   = shift_r;
  assign bus.Busy    = busy_r;
  assign bus.Done    = done_r;

endmodule

// File: tb/tb_multiplier_control.sv
// -----------------------------------------------------------------------------
// tb_multiplier_control
//   Self-checking bench for multiplier_control (WIDTH = 8). Expected strobe
//   traces are derived from the press time and the multiplier bits: press,
//   two synchronizer cycles, CLR, then WIDTH add/shift pairs, then Done.
// -----------------------------------------------------------------------------
module tb_multiplier_control;

  localparam int W = 8;
`ifdef MULT_CTRL_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  // Output vector packing: {ClearXA, LoadB, Add, Sub, Shift, Busy, Done}
  localparam logic [6:0] V_ZERO  = 7'b0000000;
  localparam logic [6:0] V_CLR   = 7'b1000010;
  localparam logic [6:0] V_LOAD  = 7'b1100000;
  localparam logic [6:0] V_SHIFT = 7'b0000110;
  localparam logic [6:0] V_DONE  = 7'b0000001;

  typedef struct {
    logic [7:0] m;
    bit         both;
    bit         toggle;
    int         exp_add;
    int         exp_sub;
  } vec_t;

  logic Clk;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[8];

  multiplier_control_if mif ();

  multiplier_control #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (mif.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] outs();
    return {mif.ClearXA, mif.LoadB, mif.Add, mif.Sub, mif.Shift, mif.Busy, mif.Done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: expected outputs c cycles after Run goes low (sampled after edge c).
  function automatic logic [6:0] exp_vec(input int c, input logic [7:0] m);
    int   k;
    int   i;
    logic mb;
    logic last;
    if (c < 3) return V_ZERO;
    if (c == 3) return V_CLR;
    if (c <= 3 + 2 * W) begin
      k = c - 3;
      if (k % 2 == 0) return V_SHIFT;
      i    = (k - 1) / 2;
      mb   = m[i];
      last = SIGNED_MODE && (i == W - 1);
      return {2'b00, mb & ~last, mb & last, 1'b0, 1'b1, 1'b0};
    end
    return V_DONE;
  endfunction

  function automatic int exp_adds(input logic [7:0] m);
    return SIGNED_MODE ? $countones(m[6:0]) : $countones(m);
  endfunction

  function automatic int exp_subs(input logic [7:0] m);
    return (SIGNED_MODE && m[7]) ? 1 : 0;
  endfunction

  // One multiply from Run press to Run release; abort_c > 0 stops after that sample.
  task automatic run_mult(input logic [7:0] m, input bit both, input bit toggle,
                          input int hold_extra, input int abort_c);
    int adds;
    int subs;
    int shifts;
    int loads;
    adds = 0; subs = 0; shifts = 0; loads = 0;
    mif.Run = 1'b0;
    if (both) mif.ClearA_LoadB = 1'b0;
    mif.M = 1'($urandom);
    for (int c = 1; c <= 4 + 2 * W; c++) begin
      @(negedge Clk);
      check($sformatf("mult m=%0h c=%0d", m, c), 32'(outs()), 32'(exp_vec(c, m)));
      adds   += int'(mif.Add);
      subs   += int'(mif.Sub);
      shifts += int'(mif.Shift);
      loads  += int'(mif.LoadB);
      if (abort_c > 0 && c == abort_c) return;
      // Present M for the coming cycle; outside ADD it must be ignored.
      if (c + 1 >= 4 && c + 1 <= 3 + 2 * W && ((c + 1 - 4) % 2 == 0))
        mif.M = m[(c + 1 - 4) / 2];
      else
        mif.M = 1'($urandom);
      if (both && c == 5) mif.ClearA_LoadB = 1'b1;
      if (toggle && c >= 4 && c <= 14) mif.ClearA_LoadB = 1'($urandom_range(0, 1));
      if (toggle && c == 15) mif.ClearA_LoadB = 1'b1;
    end
    for (int h = 0; h < hold_extra; h++) begin
      @(negedge Clk);
      check("done held", 32'(outs()), 32'(V_DONE));
    end
    mif.Run = 1'b1;
    @(negedge Clk);
    check("done release+1", 32'(outs()), 32'(V_DONE));
    @(negedge Clk);
    check("done release+2", 32'(outs()), 32'(V_DONE));
    @(negedge Clk);
    check("done release+3", 32'(outs()), 32'(V_ZERO));
    check("add count", 32'(adds), 32'(exp_adds(m)));
    check("sub count", 32'(subs), 32'(exp_subs(m)));
    check("shift count", 32'(shifts), 32'(W));
    check("load count", 32'(loads), 32'd0);
  endtask

  initial begin
    tbl[0] = '{m: 8'hFF, both: 1'b0, toggle: 1'b0, exp_add: 0, exp_sub: 0};
    tbl[1] = '{m: 8'h00, both: 1'b0, toggle: 1'b0, exp_add: 0, exp_sub: 0};
    tbl[2] = '{m: 8'h7F, both: 1'b0, toggle: 1'b0, exp_add: 0, exp_sub: 0};
    tbl[3] = '{m: 8'hA5, both: 1'b1, toggle: 1'b0, exp_add: 0, exp_sub: 0};
    tbl[4] = '{m: 8'h3C, both: 1'b0, toggle: 1'b1, exp_add: 0, exp_sub: 0};
    for (int i = 5; i < 8; i++)
      tbl[i] = '{m: 8'($urandom), both: 1'($urandom), toggle: 1'($urandom),
                 exp_add: 0, exp_sub: 0};
    for (int i = 0; i < 8; i++) begin
      tbl[i].exp_add = exp_adds(tbl[i].m);
      tbl[i].exp_sub = exp_subs(tbl[i].m);
    end

    Reset = 1'b0;
    mif.Run = 1'b1;
    mif.ClearA_LoadB = 1'b1;
    mif.M = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset outputs", 32'(outs()), 32'(V_ZERO));
    Reset = 1'b1;
    @(negedge Clk);
    check("idle outputs", 32'(outs()), 32'(V_ZERO));

    // ClearA_LoadB held four cycles in IDLE.
    mif.ClearA_LoadB = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clk);
      check($sformatf("load c=%0d", c), 32'(outs()),
            32'((c >= 3 && c <= 6) ? V_LOAD : V_ZERO));
      if (c == 4) mif.ClearA_LoadB = 1'b1;
    end

    for (int i = 0; i < 8; i++) begin
      run_mult(tbl[i].m, tbl[i].both, tbl[i].toggle, 1 + (i % 3), 0);
      for (int c = 0; c < 2; c++) begin
        @(negedge Clk);
        check("idle between", 32'(outs()), 32'(V_ZERO));
      end
    end

    // Reset in the 5th ADD cycle, then a fresh full multiply.
    run_mult(8'hFF, 1'b0, 1'b0, 0, 12);
    Reset = 1'b0;
    #1;
    check("async reset", 32'(outs()), 32'(V_ZERO));
    mif.Run = 1'b1;
    @(posedge Clk);
    #1;
    check("reset next edge", 32'(outs()), 32'(V_ZERO));
    @(negedge Clk);
    Reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      check("idle after reset", 32'(outs()), 32'(V_ZERO));
    end
    run_mult(8'($urandom), 1'b0, 1'b0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_control.md
# multiplier_control

Sequencing controller for the shift-add multiplier datapath: it turns the active-low Run and ClearA_LoadB push-buttons into per-cycle strobes for the A/B/X registers and the adder. It sits between the board buttons and the multiplier datapath. One button press produces exactly one complete multiply of WIDTH add/shift iterations, and the controller then waits for the button to be released.

## Interface
- WIDTH, 8: operand width; number of add/shift iterations per multiply (≥2).
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state.
- Run  in  1  raw push-button, active-low; starts a multiply.
- ClearA_LoadB  in  1  raw push-button, active-low; loads B from switches and clears X/A.
- M  in  1  current LSB of register B (multiplier bit), from datapath.
- ClearXA  out  1  clear X and A registers this cycle.
- LoadB  out  1  load B from switches this cycle.
- Add  out  1  A <= A + S this cycle.
- Sub  out  1  A <= A − S this cycle.
- Shift  out  1  arithmetic right shift of X:A:B this cycle.
- Busy  out  1  multiply in progress.
- Done  out  1  result valid; held until Run is released.

## Operation
- Run and ClearA_LoadB each pass through a 2-flop synchronizer. Synchronized values are runs and clrs, both still active-low.
- States: IDLE, CLR, ADD, SHIFT, HOLD. Iteration counter cnt is $clog2(WIDTH+1) bits.
- IDLE:
  - runs==0 → CLR.
  - Otherwise, if clrs==0, assert LoadB=1 and ClearXA=1 for every cycle the button is held.
  - Run has priority when both buttons are pressed.
- CLR: ClearXA=1, cnt←0, → ADD.
- ADD:
  - Add = M, except on the final iteration when the signed feature is compiled in (see Configuration).
  - → SHIFT.
- SHIFT: Shift=1, cnt←cnt+1. If cnt+1==WIDTH → HOLD, else → ADD.
- HOLD: Done=1. runs==1 → IDLE; otherwise stay in HOLD (no re-trigger while Run is held).
- Busy=1 in CLR, ADD and SHIFT.
- ClearA_LoadB is ignored in every state except IDLE.
- Outputs are decoded from the state register; Add/Sub additionally gate on M.
- Add, Sub, Shift, ClearXA and LoadB are mutually exclusive in every cycle except the IDLE load cycle, where LoadB and ClearXA are both 1.
- Reset asserted mid-operation: immediately go to IDLE, cnt=0, synchronizers to 1 (released).

## Timing
- Reset values: ClearXA=0, LoadB=0, Add=0, Sub=0, Shift=0, Busy=0, Done=0; state IDLE; cnt=0.
- Button-to-state latency: 2 cycles of synchronizer, then 1 cycle to leave IDLE.
- From CLR entry:
  - ADD/SHIFT alternate for 2·WIDTH cycles.
  - HOLD is entered 2·WIDTH+1 cycles after CLR entry; WIDTH=8 gives 17 cycles.
- M is sampled in the ADD cycle. The datapath updates B only in SHIFT, so M is stable during ADD.
- A Run pulse shorter than 3 cycles may be missed. If the pulse reaches runs==0 it completes a full multiply.

## Configuration
- MULT_CTRL_SIGNED_EN defined: in the ADD cycle with cnt==WIDTH−1, assert Sub=M and Add=0. This gives a two's-complement signed multiply.
- Not defined: Sub is tied to 0 and every iteration uses Add=M (unsigned multiply).

## Structure
- Package mult_pkg holds:
  - mult_state_t enum {IDLE, CLR, ADD, SHIFT, HOLD}.
  - MULT_WIDTH_DEFAULT = 8.
- Sub-module sync_button: 2-flop synchronizer, async active-low reset to 1. Instantiated twice (Run, ClearA_LoadB).

## Test plan
- Reset low during the 5th ADD cycle → all outputs 0 next edge, state IDLE; Run released then pressed again → full 16-cycle multiply.
- ClearA_LoadB held low 4 cycles in IDLE → LoadB=ClearXA=1 for 4 consecutive cycles (after 2-cycle sync delay), Busy=0.
- Run pressed, M=1 every iteration, WIDTH=8, macro undefined:
  - 8 Add pulses and 8 Shift pulses alternating.
  - Sub never 1.
  - Done=1 17 cycles after ClearXA.
  - Done holds while Run low, returns to 0 one cycle after runs=1.
- Same as above with MULT_CTRL_SIGNED_EN:
  - 7 Add pulses, then a Sub pulse on the 8th ADD cycle.
  - With M=0 on the 8th iteration: neither Add nor Sub.
- Run and ClearA_LoadB pressed simultaneously in IDLE → CLR path taken, LoadB never asserted.
- ClearA_LoadB toggled during Busy → no LoadB pulse, sequence unchanged.
